// File: rtl/pe_pkg.sv
// Shared constants, FSM state type and count clamp for the PE result reader.
// Address width is 8 bits; the clamp keeps a set within the memory depth.
package pe_pkg;

  localparam int MAX_MEM_SIZE = 128;
  localparam int DATA_W       = 32;
  localparam int ADR_W        = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FINISH
  } state_e;

  function automatic logic [ADR_W-1:0] clamp_count(
    input logic [ADR_W-1:0] rc,
    input logic [ADR_W:0]   lim
  );
    return ({1'b0, rc} > lim) ? lim[ADR_W-1:0] : rc;
  endfunction

endpackage

// File: rtl/pe_rd_fifo.sv
// Two-entry FIFO between the result-memory read port and the output stream.
// A push while full is accepted only alongside a pop.
module pe_rd_fifo #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_push;
  logic         w_pop;

  assign full   = (r_cnt == 2'd2);
  assign empty  = (r_cnt == 2'd0);
  assign w_pop  = pop && !empty;
  assign w_push = push && (!full || w_pop);
  assign dout   = r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= din;
        r_wp        <= ~r_wp;
      end
      if (w_pop) begin
        r_rp <= ~r_rp;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/pe_result_reader.sv
// Streams a finished PE result set out of the result memory.
// Reads are throttled so buffered plus in-flight words never exceed two.
module pe_result_reader #(
  parameter int MAX_MEM_SIZE = pe_pkg::MAX_MEM_SIZE,
  parameter int DATA_W       = pe_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [7:0]               res_count,
  input  logic [31:0]              pe_num,
  output logic                     rd_en,
  output logic [pe_pkg::ADR_W-1:0] rd_adr,
  input  logic [DATA_W-1:0]        rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [31:0]              out_tag,
  output logic                     busy,
  output logic                     done
);

  import pe_pkg::*;

  localparam logic [ADR_W:0] LIM = (ADR_W+1)'(MAX_MEM_SIZE);

  state_e           r_state;
  state_e           w_next;
  logic [ADR_W-1:0] r_count;
  logic [ADR_W-1:0] r_adr;
  logic [ADR_W-1:0] r_out_idx;
  logic [31:0]      r_tag;
  logic             r_inflight;
  logic [ADR_W-1:0] w_clamped;
  logic [ADR_W-1:0] w_cnt_m1;
  logic             w_start_ok;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic             w_last_rd;
  logic             w_fin_hs;
  logic [1:0]       w_occ;
  logic [1:0]       w_pend;

  assign w_clamped  = clamp_count(res_count, LIM);
  assign w_cnt_m1   = r_count - ADR_W'(1);
  assign w_start_ok = (r_state == IDLE) && start;

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  // Count this cycle's pop so a full-rate stream keeps issuing reads.
  assign w_occ  = w_full ? 2'd2 : {1'b0, !w_empty};
  assign w_pend = w_occ - {1'b0, w_pop} + {1'b0, r_inflight};
  assign rd_en  = (r_state == READ) && (w_pend < 2'd2);

  assign w_last_rd = rd_en && (r_adr == w_cnt_m1);
  assign out_last  = out_valid && (r_out_idx == w_cnt_m1);
  assign w_fin_hs  = w_pop && out_last;

  assign rd_adr  = r_adr;
  assign out_tag = r_tag;
  assign busy    = (r_state != IDLE);
  assign done    = (r_state == FINISH);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next = (w_clamped == '0) ? FINISH : READ;
        end
      end
      READ: begin
        if (w_last_rd) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        if (w_fin_hs) begin
          w_next = FINISH;
        end
      end
      FINISH:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_adr      <= '0;
      r_out_idx  <= '0;
      r_tag      <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rd_en;
      if (w_start_ok) begin
        r_count   <= w_clamped;
        r_tag     <= pe_num;
        r_adr     <= '0;
        r_out_idx <= '0;
      end else begin
        if (rd_en) begin
          r_adr <= r_adr + ADR_W'(1);
        end
        if (w_pop) begin
          r_out_idx <= r_out_idx + ADR_W'(1);
        end
      end
    end
  end

  pe_rd_fifo #(
    .W (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   (rd_data),
    .dout  (out_data),
    .full  (w_full),
    .empty (w_empty)
  );

endmodule

// File: tb/tb_pe_result_reader.sv
// Bench for pe_result_reader: table vectors, hand sequences and random sets
// against a queue model of the expected word stream.
module tb_pe_result_reader;

  localparam int MAXM = 128;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  res_count = 8'd0;
  logic [31:0] pe_num = 32'd0;
  logic        rd_en;
  logic [7:0]  rd_adr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic [31:0] out_tag;
  logic        busy;
  logic        done;

  logic [31:0] mem [256];
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          rc;
    logic [31:0] tag;
    int          mode;
    int          rs_k;
    logic [31:0] base;
    int          exp_words;
    int          exp_lat;
  } vec_t;

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= rd_en ? mem[rd_adr] : 32'hDEAD_BEEF;

  pe_result_reader #(
    .MAX_MEM_SIZE (MAXM),
    .DATA_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_count (res_count),
    .pe_num    (pe_num),
    .rd_en     (rd_en),
    .rd_adr    (rd_adr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_tag   (out_tag),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 256; i++) mem[i] = base + 32'(i);
  endtask

  // mode 0: ready high, 1: ready 1010..., 2: random ready
  task automatic run_set(input int rc, input logic [31:0] tag,
                         input int mode, input int rs_k,
                         output int words, output int nrd,
                         output int lat, output int gap,
                         output int last_k);
    logic [31:0] q[$];
    logic [31:0] pd;
    logic [31:0] pt;
    int n;
    int acc;
    int lim;
    bit pv;
    bit pr;
    bit pl;
    bit fin;
    n = (rc > MAXM) ? MAXM : rc;
    for (int i = 0; i < n; i++) q.push_back(mem[i]);
    acc = 0;
    nrd = 0;
    lat = -1;
    gap = -1;
    last_k = 0;
    pv = 0;
    pr = 0;
    pl = 0;
    pd = '0;
    pt = '0;
    fin = 0;
    lim = 8 * n + 20;
    @(negedge clk);
    start = 1'b1;
    res_count = rc[7:0];
    pe_num = tag;
    out_ready = 1'b0;
    for (int k = 1; k <= lim && !fin; k++) begin
      @(negedge clk);
      start = (k == rs_k);
      if (k == rs_k) begin
        pe_num = 32'd7;
        res_count = 8'd3;
      end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = k[0];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      chk("busy", 32'(busy), 32'd1);
      if (pv && !pr)
        chk("hold", 32'(out_valid && out_data == pd &&
                        out_last == pl && out_tag == pt), 32'd1);
      chk("inflight", 32'((nrd - acc) <= 2), 32'd1);
      if (rd_en) begin
        chk("rd_adr", {24'd0, rd_adr}, 32'(nrd));
        chk("rd_extra", 32'(nrd < n), 32'd1);
        nrd++;
      end
      if (out_valid) begin
        if (lat < 0) lat = k - 1;
        if (out_ready) begin
          if (q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL extra_word: got %0h expected none", out_data);
          end else begin
            chk("data", out_data, q.pop_front());
            chk("last", 32'(out_last), 32'(acc == n - 1));
            chk("tag", out_tag, tag);
            acc++;
            last_k = k;
          end
        end
      end
      if (done) begin
        chk("done_words", 32'(acc), 32'(n));
        gap = k - last_k;
        fin = 1;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      pl = out_last;
      pt = out_tag;
    end
    if (!fin) begin
      n_vec++;
      n_bad++;
      $display("FAIL timeout: no done after %0d cycles", lim);
    end
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_done", 32'(done), 32'd0);
    chk("post_valid", 32'(out_valid), 32'd0);
    words = acc;
  endtask

  initial begin
    vec_t tbl[8];
    int words;
    int nrd;
    int lat;
    int gap;
    int last_k;
    int acc;
    int rc;
    int n;
    int mode;

    tbl[0] = '{4,   32'd3,  0, 0, 32'h100,  4,   2};
    tbl[1] = '{0,   32'd5,  0, 0, 32'h200,  0,   -1};
    tbl[2] = '{8,   32'd9,  1, 0, 32'h300,  8,   2};
    tbl[3] = '{200, 32'd11, 0, 0, 32'h1000, 128, 2};
    tbl[4] = '{8,   32'd3,  0, 2, 32'h400,  8,   2};
    tbl[5] = '{1,   32'd12, 2, 0, 32'h500,  1,   2};
    tbl[6] = '{129, 32'd14, 1, 5, 32'h2000, 128, 2};
    tbl[7] = '{2,   32'd15, 2, 1, 32'h600,  2,   2};

    fill(32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_tag", out_tag, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 8; t++) begin
      fill(tbl[t].base);
      run_set(tbl[t].rc, tbl[t].tag, tbl[t].mode, tbl[t].rs_k,
              words, nrd, lat, gap, last_k);
      chk("words", 32'(words), 32'(tbl[t].exp_words));
      chk("reads", 32'(nrd), 32'(tbl[t].exp_words));
      chk("first_valid", 32'(lat), 32'(tbl[t].exp_lat));
      chk("done_gap", 32'(gap), 32'd1);
      if (tbl[t].mode == 0 && tbl[t].exp_words > 0)
        chk("throughput", 32'(last_k - lat - 1), 32'(tbl[t].exp_words - 1));
    end

    // reset in the middle of a six-word set
    fill(32'h700);
    @(negedge clk);
    start = 1'b1;
    res_count = 8'd6;
    pe_num = 32'd21;
    out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 40 && acc < 3; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (out_valid) acc++;
    end
    chk("pre_reset_words", 32'(acc), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rd_en", 32'(rd_en), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_last", 32'(out_last), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    chk("mid_data", out_data, 32'd0);
    chk("mid_tag", out_tag, 32'd0);
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_hold_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rel_done", 32'(done), 32'd0);
    fill(32'h900);
    run_set(2, 32'd22, 0, 0, words, nrd, lat, gap, last_k);
    chk("restart_words", 32'(words), 32'd2);
    chk("restart_reads", 32'(nrd), 32'd2);

    for (int r = 0; r < 20; r++) begin
      rc = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 140));
      n = (rc > MAXM) ? MAXM : rc;
      mode = int'($urandom_range(0, 2));
      fill($urandom);
      run_set(rc, $urandom, mode, int'($urandom_range(0, 6)),
              words, nrd, lat, gap, last_k);
      chk("rnd_words", 32'(words), 32'(n));
      chk("rnd_reads", 32'(nrd), 32'(n));
      chk("rnd_first_valid", 32'(lat), (n > 0) ? 32'd2 : 32'hFFFF_FFFF);
      chk("rnd_done_gap", 32'(gap), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
